// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares one 7-segment display driver between three
// requesters, with a minimum owner tenure and a blanking gap on every hand-over.
module display_arbiter #(
  parameter int          HOLD_W       = 24,
  parameter logic [HOLD_W-1:0] MIN_HOLD = 24'd12000000,
  parameter logic [7:0]  BLANK_CYCLES = 8'd16,
  parameter logic [15:0] BLANK_DATA   = 16'h0000,
  parameter logic [3:0]  BLANK_PTS    = 4'b1111,
  parameter logic [1:0]  BLANK_MODE   = 2'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  i_req,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  input  logic [15:0] i_data2,
  input  logic [3:0]  i_pts0,
  input  logic [3:0]  i_pts1,
  input  logic [3:0]  i_pts2,
  input  logic [1:0]  i_mode0,
  input  logic [1:0]  i_mode1,
  input  logic [1:0]  i_mode2,
  output logic [2:0]  o_grant,
  output logic [1:0]  o_owner,
  output logic        o_busy,
  output logic [15:0] o_data,
  output logic [3:0]  o_pts,
  output logic [1:0]  o_mode
);

  // Zero-valued parameters degrade to a single cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MIN_HOLD == '0) ? '0 : MIN_HOLD - HOLD_W'(1);
  localparam logic [7:0] BLANK_LAST =
    (BLANK_CYCLES == 8'd0) ? 8'd0 : BLANK_CYCLES - 8'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_owner;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [7:0]        r_blank_cnt;
  logic [2:0]        r_grant;
  logic              r_busy;
  logic [15:0]       r_data;
  logic [3:0]        r_pts;
  logic [1:0]        r_mode;

  state_t            w_state_nxt;
  logic [1:0]        w_owner_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [7:0]        w_blank_nxt;
  logic [2:0]        w_grant_nxt;
  logic              w_busy_nxt;
  logic [15:0]       w_data_nxt;
  logic [3:0]        w_pts_nxt;
  logic [1:0]        w_mode_nxt;
  logic [1:0]        w_pick;
  logic              w_any_req;
  logic              w_own_req;
  logic              w_other_req;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Search order starts just after the last owner; the last owner itself comes last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] c0, c1, c2;
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (req[c0])      rr_pick = c0;
    else if (req[c1]) rr_pick = c1;
    else              rr_pick = c2;
  endfunction

  assign w_pick      = rr_pick(r_owner, i_req);
  assign w_any_req   = |i_req;
  assign w_own_req   = |(i_req & onehot(r_owner));
  assign w_other_req = |(i_req & ~onehot(r_owner));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= 2'd2;
      r_hold_cnt  <= '0;
      r_blank_cnt <= 8'd0;
      r_grant     <= 3'b000;
      r_busy      <= 1'b0;
      r_data      <= BLANK_DATA;
      r_pts       <= BLANK_PTS;
      r_mode      <= BLANK_MODE;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= w_busy_nxt;
      r_data      <= w_data_nxt;
      r_pts       <= w_pts_nxt;
      r_mode      <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold_cnt;
    w_blank_nxt = r_blank_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_pick;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OWN: begin
        // Release wins over preempt; both lead to the same blank gap.
        if (!w_own_req) begin
          w_state_nxt = S_BLANK;
          w_blank_nxt = 8'd0;
        end else if ((r_hold_cnt == HOLD_LAST) && w_other_req) begin
          w_state_nxt = S_BLANK;
          w_blank_nxt = 8'd0;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
        end else begin
          w_hold_nxt  = r_hold_cnt;
        end
      end
      S_BLANK: begin
        if (r_blank_cnt == BLANK_LAST) begin
          w_blank_nxt = 8'd0;
          if (w_any_req) begin
            w_state_nxt = S_OWN;
            w_owner_nxt = w_pick;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_blank_nxt = r_blank_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so grant and data change on the same edge.
  always_comb begin
    w_grant_nxt = 3'b000;
    w_busy_nxt  = 1'b0;
    w_data_nxt  = BLANK_DATA;
    w_pts_nxt   = BLANK_PTS;
    w_mode_nxt  = BLANK_MODE;
    case (w_state_nxt)
      S_OWN: begin
        w_grant_nxt = onehot(w_owner_nxt);
        w_busy_nxt  = 1'b1;
        case (w_owner_nxt)
          2'd0:    begin w_data_nxt = i_data0; w_pts_nxt = i_pts0; w_mode_nxt = i_mode0; end
          2'd1:    begin w_data_nxt = i_data1; w_pts_nxt = i_pts1; w_mode_nxt = i_mode1; end
          2'd2:    begin w_data_nxt = i_data2; w_pts_nxt = i_pts2; w_mode_nxt = i_mode2; end
          default: begin w_data_nxt = BLANK_DATA; w_pts_nxt = BLANK_PTS; w_mode_nxt = BLANK_MODE; end
        endcase
      end
      S_BLANK: begin
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_owner = r_owner;
  assign o_busy  = r_busy;
  assign o_data  = r_data;
  assign o_pts   = r_pts;
  assign o_mode  = r_mode;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed, table-driven bench for display_arbiter with MIN_HOLD=8, BLANK_CYCLES=2.
module tb_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_req;
  logic [15:0] i_data0, i_data1, i_data2;
  logic [3:0]  i_pts0, i_pts1, i_pts2;
  logic [1:0]  i_mode0, i_mode1, i_mode2;
  logic [2:0]  o_grant;
  logic [1:0]  o_owner;
  logic        o_busy;
  logic [15:0] o_data;
  logic [3:0]  o_pts;
  logic [1:0]  o_mode;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  req;
    int          n;
    logic [2:0]  g;
    logic [1:0]  own;
    logic        busy;
    logic [15:0] d1;
  } step_t;

  step_t tbl[$];

  display_arbiter #(
    .HOLD_W(24), .MIN_HOLD(24'd8), .BLANK_CYCLES(8'd2),
    .BLANK_DATA(16'h0000), .BLANK_PTS(4'b1111), .BLANK_MODE(2'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req),
    .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
    .i_pts0(i_pts0), .i_pts1(i_pts1), .i_pts2(i_pts2),
    .i_mode0(i_mode0), .i_mode1(i_mode1), .i_mode2(i_mode2),
    .o_grant(o_grant), .o_owner(o_owner), .o_busy(o_busy),
    .o_data(o_data), .o_pts(o_pts), .o_mode(o_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected driver values follow from the expected grant and the bench's own inputs.
  task automatic check_out(input string tag, input logic [2:0] g, input logic [1:0] own, input logic busy);
    logic [15:0] ed;
    logic [3:0]  ep;
    logic [1:0]  em;
    case (g)
      3'b001:  begin ed = i_data0; ep = i_pts0; em = i_mode0; end
      3'b010:  begin ed = i_data1; ep = i_pts1; em = i_mode1; end
      3'b100:  begin ed = i_data2; ep = i_pts2; em = i_mode2; end
      default: begin ed = 16'h0000; ep = 4'b1111; em = 2'd2; end
    endcase
    check({tag, ".grant"}, {13'd0, o_grant}, {13'd0, g});
    check({tag, ".owner"}, {14'd0, o_owner}, {14'd0, own});
    check({tag, ".busy"},  {15'd0, o_busy},  {15'd0, busy});
    check({tag, ".data"},  o_data, ed);
    check({tag, ".pts"},   {12'd0, o_pts},   {12'd0, ep});
    check({tag, ".mode"},  {14'd0, o_mode},  {14'd0, em});
  endtask

  initial begin
    rst_n   = 1'b0;
    i_req   = 3'b111;
    i_data0 = 16'hA0A0; i_data1 = 16'h1234; i_data2 = 16'hC2C2;
    i_pts0  = 4'h1;     i_pts1  = 4'h2;     i_pts2  = 4'h4;
    i_mode0 = 2'd0;     i_mode1 = 2'd1;     i_mode2 = 2'd3;

    // Round-robin with req=111 from reset
    tbl.push_back('{3'b111,   8, 3'b001, 2'd0, 1'b1, 16'h1234});
    tbl.push_back('{3'b111,   2, 3'b000, 2'd0, 1'b1, 16'h1234});
    tbl.push_back('{3'b111,   8, 3'b010, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b111,   2, 3'b000, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b111,   8, 3'b100, 2'd2, 1'b1, 16'h1234});
    tbl.push_back('{3'b111,   2, 3'b000, 2'd2, 1'b1, 16'h1234});
    tbl.push_back('{3'b111,   1, 3'b001, 2'd0, 1'b1, 16'h1234});
    // Early release at tenure cycle 2, then idle, then re-request
    tbl.push_back('{3'b001,   1, 3'b001, 2'd0, 1'b1, 16'h1234});
    tbl.push_back('{3'b000,   2, 3'b000, 2'd0, 1'b1, 16'h1234});
    tbl.push_back('{3'b000,   4, 3'b000, 2'd0, 1'b0, 16'h1234});
    tbl.push_back('{3'b001,   1, 3'b001, 2'd0, 1'b1, 16'h1234});
    // Hand over to requester 1 and hold it alone for 100 cycles
    tbl.push_back('{3'b010,   2, 3'b000, 2'd0, 1'b1, 16'h1234});
    tbl.push_back('{3'b010,   1, 3'b010, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b010,  50, 3'b010, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b010,  50, 3'b010, 2'd1, 1'b1, 16'hBEEF});
    // Fresh tenure for 1, requester 2 arrives at tenure cycle 3
    tbl.push_back('{3'b000,   2, 3'b000, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b000,   1, 3'b000, 2'd1, 1'b0, 16'h1234});
    tbl.push_back('{3'b010,   3, 3'b010, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b110,   5, 3'b010, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b110,   2, 3'b000, 2'd1, 1'b1, 16'h1234});
    tbl.push_back('{3'b110,   1, 3'b100, 2'd2, 1'b1, 16'h1234});
    // Move ownership to 0, then enter blank for the reset test
    tbl.push_back('{3'b001,   2, 3'b000, 2'd2, 1'b1, 16'h1234});
    tbl.push_back('{3'b001,   1, 3'b001, 2'd0, 1'b1, 16'h1234});
    tbl.push_back('{3'b000,   1, 3'b000, 2'd0, 1'b1, 16'h1234});

    #12;
    check_out("reset", 3'b000, 2'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      i_req   = tbl[k].req;
      i_data1 = tbl[k].d1;
      for (int c = 0; c < tbl[k].n; c++) begin
        @(posedge clk);
        #1;
        check_out($sformatf("step%0d.%0d", k, c), tbl[k].g, tbl[k].own, tbl[k].busy);
      end
    end

    // Reset asserted mid-blank aborts at once
    #2;
    rst_n = 1'b0;
    #1;
    check_out("midblank_reset", 3'b000, 2'd2, 1'b0);
    i_req = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("after_reset_pick", 3'b100, 2'd2, 1'b1);

    // Data pass-through takes exactly one edge
    i_data2 = 16'h5A5A;
    #1;
    check("latency.before", o_data, 16'hC2C2);
    @(posedge clk);
    #1;
    check_out("latency.after", 3'b100, 2'd2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
